// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_if_pkg
// Purpose  : Shared definitions for the mem_* request bus. Requester tags and
//            bus widths are common to every initiator and target on the bus.
//            The responder state type is also defined here.
// Revision : 1.0  initial release
// ============================================================================
package mem_if_pkg;

    // Requester tags. ID_NONE on the return path means "no data this cycle".
    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_DC   = 2'd1;
    localparam logic [1:0] ID_IC   = 2'd2;
    localparam logic [1:0] ID_FB   = 2'd3;

    localparam int MEM_ADDR_W = 30;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_MASK_W = 4;

    typedef enum logic [0:0] {
        RESP_INIT  = 1'b0,
        RESP_READY = 1'b1
    } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_pipe
// Purpose  : Read-return delay line. Carries {valid,id} for READ_LATENCY
//            stages. Data enters one stage late, because the RAM output
//            register is already stage 0. The data stages only load behind
//            a valid read, so out_data holds its last value between returns.
// Ports    : clock, reset_n        clock / async active-low reset
//            in_valid, in_id       accepted read and its tag (stage 0 input)
//            in_data               RAM output register (aligned to stage 0)
//            out_valid, out_id     read returning this cycle and its tag
//            out_data              returned data
// Revision : 1.0  initial release
// ============================================================================
module mem_resp_pipe
    import mem_if_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [1:0]            in_id,
    input  logic [MEM_DATA_W-1:0] in_data,
    output logic                  out_valid,
    output logic [1:0]            out_id,
    output logic [MEM_DATA_W-1:0] out_data
);

    logic [READ_LATENCY-1:0] r_valid;
    logic [1:0]              r_id [0:READ_LATENCY-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_id[k] <= ID_NONE;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_id[0]    <= in_id;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_id[k]    <= r_id[k-1];
            end
        end
    end

    assign out_valid = r_valid[READ_LATENCY-1];
    assign out_id    = r_id[READ_LATENCY-1];

    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign out_data = in_data;
        end else begin : g_delay
            // r_data[k] travels alongside r_valid[k]; stage 0 is the RAM register.
            logic [MEM_DATA_W-1:0] r_data [1:READ_LATENCY-1];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 1; k < READ_LATENCY; k++) begin
                        r_data[k] <= '0;
                    end
                end else begin
                    if (r_valid[0]) begin
                        r_data[1] <= in_data;
                    end
                    for (int k = 2; k < READ_LATENCY; k++) begin
                        if (r_valid[k-1]) begin
                            r_data[k] <= r_data[k-1];
                        end
                    end
                end
            end

            assign out_data = r_data[READ_LATENCY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_bram_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bram_responder
// Purpose  : Block-RAM target on the mem_* bus. It returns read data tagged
//            with the requester id after a fixed latency. It can optionally
//            clear the whole RAM after reset, and can inject pseudo-random
//            waitrequest stalls to exercise the initiators.
// Ports    : clock, reset_n               clock / async active-low reset
//            mem_waitrequest              1 = request not accepted this cycle
//            mem_id, mem_address          requester tag, word address
//            mem_read, mem_write          request strobes
//            mem_writedata, mem_writedatamask  write data, byte enables
//            mem_readdata, mem_readdataid returned data and tag (0 = none)
//            proto_error                  sticky read+write collision flag
// Revision : 1.0  initial release
// ============================================================================
module mem_bram_responder
    import mem_if_pkg::*;
#(
    parameter int          ADDR_BITS      = 12,
    parameter int          READ_LATENCY   = 2,
    parameter int          CLEAR_ON_RESET = 1,
    parameter int          STALL_EN       = 0,
    parameter logic [15:0] STALL_SEED     = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  mem_waitrequest,
    input  logic [1:0]            mem_id,
    input  logic [MEM_ADDR_W-1:0] mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_DATA_W-1:0] mem_writedata,
    input  logic [MEM_MASK_W-1:0] mem_writedatamask,
    output logic [MEM_DATA_W-1:0] mem_readdata,
    output logic [1:0]            mem_readdataid,
    output logic                  proto_error
);

    localparam int          DEPTH       = 2 ** ADDR_BITS;
    localparam resp_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? RESP_INIT : RESP_READY;

    resp_state_t           r_state, w_state_nxt;
    logic [ADDR_BITS-1:0]  r_init_cnt, w_init_cnt_nxt;
    logic [15:0]           r_lfsr, w_lfsr_nxt;
    logic                  r_wait, w_wait_nxt;
    logic                  r_proto_err;

    logic                  w_accept, w_wr_en, w_rd_en, w_collide;
    logic [ADDR_BITS-1:0]  w_word;
    logic                  w_ram_we;
    logic [ADDR_BITS-1:0]  w_ram_addr;
    logic [MEM_MASK_W-1:0] w_ram_be;
    logic [MEM_DATA_W-1:0] w_ram_wd;
    logic [MEM_DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [MEM_DATA_W-1:0] r_ram_q;

    logic                  w_pipe_valid;
    logic [1:0]            w_pipe_id;

    // ------------------------------------------------------------------
    // Control FSM and stall LFSR
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_lfsr_nxt     = r_lfsr;
        case (r_state)
            RESP_INIT: begin
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == {ADDR_BITS{1'b1}}) begin
                    w_state_nxt = RESP_READY;
                end
            end
            RESP_READY: begin
                // x^16 + x^14 + x^13 + x^11
                w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            end
            default: begin
                w_state_nxt = RESET_STATE;
            end
        endcase
        // waitrequest is computed one cycle ahead from the next state only,
        // so it never depends on the incoming read/write strobes.
        w_wait_nxt = (w_state_nxt != RESP_READY) || ((STALL_EN != 0) && w_lfsr_nxt[0]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RESET_STATE;
            r_init_cnt <= '0;
            r_lfsr     <= STALL_SEED;
            r_wait     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_wait     <= w_wait_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_word    = mem_address[ADDR_BITS-1:0];
    assign w_accept  = (mem_read | mem_write) & ~r_wait;
    assign w_wr_en   = w_accept & mem_write;
    assign w_rd_en   = w_accept & mem_read & ~mem_write;
    assign w_collide = w_accept & mem_read & mem_write;

    generate
        if (ADDR_BITS < MEM_ADDR_W) begin : g_alias
            // Upper address bits are deliberately ignored so the RAM aliases.
            logic w_addr_unused;
            assign w_addr_unused = ^mem_address[MEM_ADDR_W-1:ADDR_BITS];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_proto_err <= 1'b0;
        end else if (w_collide) begin
            r_proto_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RAM: the clear sweep shares the write port with bus writes. No
    // accept is possible during INIT because waitrequest is held high.
    // ------------------------------------------------------------------
    always_comb begin
        w_ram_we   = w_wr_en;
        w_ram_addr = w_word;
        w_ram_be   = mem_writedatamask;
        w_ram_wd   = mem_writedata;
        if (r_state == RESP_INIT) begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_init_cnt;
            w_ram_be   = {MEM_MASK_W{1'b1}};
            w_ram_wd   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            for (int b = 0; b < MEM_MASK_W; b++) begin
                if (w_ram_be[b]) begin
                    r_mem[w_ram_addr][8*b +: 8] <= w_ram_wd[8*b +: 8];
                end
            end
        end
    end

    // A read is never accepted on the same edge as a write, so a read that
    // follows a write sees the committed word. This gives write-first
    // behaviour without a bypass path.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_q <= '0;
        end else if (w_rd_en) begin
            r_ram_q <= r_mem[w_word];
        end
    end

    mem_resp_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (w_rd_en),
        .in_id     (mem_id),
        .in_data   (r_ram_q),
        .out_valid (w_pipe_valid),
        .out_id    (w_pipe_id),
        .out_data  (mem_readdata)
    );

    assign mem_waitrequest = r_wait;
    assign mem_readdataid  = w_pipe_valid ? w_pipe_id : ID_NONE;
    assign proto_error     = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_bram_responder
// Purpose  : Directed checks on a stall-free instance (ADDR_BITS=4,
//            READ_LATENCY=2). A second instance with stalls enabled
//            (READ_LATENCY=3) is driven by a holding random initiator and
//            checked against a reference model, with a reset mid-burst.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_bram_responder;
    import mem_if_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: no stalls
    logic        a_rst_n, a_wait, a_rd, a_wr, a_perr;
    logic [1:0]  a_id, a_rdid;
    logic [29:0] a_addr;
    logic [31:0] a_wd, a_rdata;
    logic [3:0]  a_mask;

    // Instance B: stalls enabled
    logic        b_rst_n, b_wait, b_rd, b_wr, b_perr;
    logic [1:0]  b_id, b_rdid;
    logic [29:0] b_addr;
    logic [31:0] b_wd, b_rdata;
    logic [3:0]  b_mask;

    mem_bram_responder #(
        .ADDR_BITS(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .STALL_EN(0), .STALL_SEED(16'hACE1)
    ) dut_a (
        .clock(clock), .reset_n(a_rst_n), .mem_waitrequest(a_wait), .mem_id(a_id),
        .mem_address(a_addr), .mem_read(a_rd), .mem_write(a_wr), .mem_writedata(a_wd),
        .mem_writedatamask(a_mask), .mem_readdata(a_rdata), .mem_readdataid(a_rdid),
        .proto_error(a_perr)
    );

    mem_bram_responder #(
        .ADDR_BITS(4), .READ_LATENCY(3), .CLEAR_ON_RESET(1), .STALL_EN(1), .STALL_SEED(16'hACE1)
    ) dut_b (
        .clock(clock), .reset_n(b_rst_n), .mem_waitrequest(b_wait), .mem_id(b_id),
        .mem_address(b_addr), .mem_read(b_rd), .mem_write(b_wr), .mem_writedata(b_wd),
        .mem_writedatamask(b_mask), .mem_readdata(b_rdata), .mem_readdataid(b_rdid),
        .proto_error(b_perr)
    );

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     b_q[$];
    logic [31:0] b_model [0:15];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- instance A helpers ----------------
    task automatic a_idle();
        a_rd = 1'b0;
        a_wr = 1'b0;
    endtask

    task automatic a_write(input logic [29:0] addr, input logic [31:0] d, input logic [3:0] m);
        a_addr = addr; a_wd = d; a_mask = m; a_id = ID_DC; a_rd = 1'b0; a_wr = 1'b1;
        @(negedge clock);
        a_idle();
    endtask

    task automatic a_read(input logic [29:0] addr, input logic [1:0] id,
                          output logic [1:0] rid, output logic [31:0] rdat);
        a_addr = addr; a_id = id; a_rd = 1'b1; a_wr = 1'b0;
        @(negedge clock);
        a_idle();
        @(negedge clock);
        rid  = a_rdid;
        rdat = a_rdata;
    endtask

    // ---------------- instance B helpers ----------------
    task automatic b_idle();
        b_rd = 1'b0;
        b_wr = 1'b0;
    endtask

    // Advance one cycle and score any read return against the model queue.
    task automatic b_step();
        rd_exp_t e;
        @(negedge clock);
        if (b_rdid != ID_NONE) begin
            if (b_q.size() == 0) begin
                check_value("b_stale_rd", {30'd0, b_rdid}, {30'd0, ID_NONE});
            end else begin
                e = b_q.pop_front();
                check_value("b_rd_id", {30'd0, b_rdid}, {30'd0, e.id});
                check_value("b_rd_data", b_rdata, e.data);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rid;
        logic [31:0] rdat;
        int          n;

        a_rst_n = 1'b0; a_id = ID_NONE; a_addr = '0; a_wd = '0; a_mask = '0; a_idle();
        b_rst_n = 1'b0; b_id = ID_NONE; b_addr = '0; b_wd = '0; b_mask = '0; b_idle();
        repeat (3) @(negedge clock);

        // Reset state
        check_value("rst_wait", {31'd0, a_wait}, 32'd1);
        check_value("rst_rdid", {30'd0, a_rdid}, 32'd0);
        check_value("rst_rdata", a_rdata, 32'd0);
        check_value("rst_perr", {31'd0, a_perr}, 32'd0);

        // Test 1: clear sweep holds waitrequest for 16 cycles
        a_rst_n = 1'b1;
        n = 0;
        while (a_wait && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_value("t1_init_cycles", n, 32'd16);
        @(negedge clock);
        check_value("t1_wait_low", {31'd0, a_wait}, 32'd0);
        a_read(30'd5, ID_FB, rid, rdat);
        check_value("t1_rd5_id", {30'd0, rid}, 32'd3);
        check_value("t1_rd5_data", rdat, 32'd0);

        // Test 2: read-after-write next cycle, exact latency
        a_write(30'd3, 32'hDEADBEEF, 4'hF);
        a_addr = 30'd3; a_id = ID_IC; a_rd = 1'b1;
        @(negedge clock);
        a_idle();
        check_value("t2_not_early", {30'd0, a_rdid}, 32'd0);
        @(negedge clock);
        check_value("t2_id", {30'd0, a_rdid}, 32'd2);
        check_value("t2_data", a_rdata, 32'hDEADBEEF);
        @(negedge clock);
        check_value("t2_single_pulse", {30'd0, a_rdid}, 32'd0);

        // Test 3: byte-masked write
        a_write(30'd3, 32'h11223344, 4'b0101);
        a_read(30'd3, ID_DC, rid, rdat);
        check_value("t3_masked", rdat, 32'hDE22BE44);

        // Mask 0 is a no-op, aliasing of upper address bits
        a_write(30'd3, 32'hFFFFFFFF, 4'b0000);
        a_read(30'd19, ID_FB, rid, rdat);
        check_value("mask0_alias_rd", rdat, 32'hDE22BE44);
        a_write(30'h2000_0012, 32'hCAFE0002, 4'hF);
        a_read(30'd2, ID_DC, rid, rdat);
        check_value("alias_wr", rdat, 32'hCAFE0002);

        // id 0 read: invisible tag, data still updates
        a_read(30'd3, ID_NONE, rid, rdat);
        check_value("id0_tag", {30'd0, rid}, 32'd0);
        check_value("id0_data", rdat, 32'hDE22BE44);

        // Test 4: streaming reads, alternating ids, no bubbles
        for (int k = 0; k < 8; k++) begin
            a_write(30'(k), 32'hA000_0000 + 32'(k), 4'hF);
        end
        for (int c = 0; c <= 10; c++) begin
            if (c >= 2 && c < 10) begin
                check_value("t4_id", {30'd0, a_rdid}, ((c - 2) % 2 == 0) ? 32'd1 : 32'd3);
                check_value("t4_data", a_rdata, 32'hA000_0000 + 32'(c - 2));
            end else begin
                check_value("t4_quiet", {30'd0, a_rdid}, 32'd0);
            end
            if (c < 8) begin
                a_addr = 30'(c); a_id = (c % 2 == 0) ? ID_DC : ID_FB; a_rd = 1'b1; a_wr = 1'b0;
            end else begin
                a_idle();
            end
            @(negedge clock);
        end

        // Test 5: read and write together
        a_addr = 30'd9; a_wd = 32'h55AA55AA; a_mask = 4'hF; a_id = ID_IC; a_rd = 1'b1; a_wr = 1'b1;
        @(negedge clock);
        a_idle();
        for (int c = 0; c < 3; c++) begin
            check_value("t5_no_rdid", {30'd0, a_rdid}, 32'd0);
            @(negedge clock);
        end
        check_value("t5_perr_set", {31'd0, a_perr}, 32'd1);
        a_read(30'd9, ID_DC, rid, rdat);
        check_value("t5_written", rdat, 32'h55AA55AA);
        check_value("t5_perr_sticky", {31'd0, a_perr}, 32'd1);
        a_rst_n = 1'b0;
        @(negedge clock);
        check_value("t5_perr_cleared", {31'd0, a_perr}, 32'd0);
        a_rst_n = 1'b1;

        // Test 6: stalling instance vs reference model
        for (int k = 0; k < 16; k++) b_model[k] = '0;
        b_rst_n = 1'b1;
        for (int op = 0; op < 1000; op++) begin
            logic        is_rd;
            logic [3:0]  w;
            if (op == 500) begin
                b_idle();
                b_rst_n = 1'b0;
                b_q.delete();
                for (int k = 0; k < 16; k++) b_model[k] = '0;
                b_step();
                b_step();
                b_rst_n = 1'b1;
            end
            is_rd  = 1'($urandom_range(0, 1));
            b_addr = 30'($urandom_range(0, 63));
            b_id   = 2'($urandom_range(1, 3));
            b_wd   = $urandom;
            b_mask = 4'($urandom_range(0, 15));
            b_rd   = is_rd;
            b_wr   = ~is_rd;
            w      = b_addr[3:0];
            n = 0;
            while (b_wait && n < 100) begin
                b_step();
                n++;
            end
            if (b_wait) begin
                check_value("b_accept_timeout", {31'd0, b_wait}, 32'd0);
                b_idle();
                b_step();
            end else begin
                if (is_rd) begin
                    b_q.push_back('{id: b_id, data: b_model[w]});
                end else begin
                    for (int bb = 0; bb < 4; bb++) begin
                        if (b_mask[bb]) b_model[w][8*bb +: 8] = b_wd[8*bb +: 8];
                    end
                end
                b_step();
                b_idle();
                if ($urandom_range(0, 3) == 0) b_step();
            end
        end
        b_idle();
        repeat (8) b_step();
        check_value("b_drained", b_q.size(), 32'd0);
        check_value("b_no_perr", {31'd0, b_perr}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
